// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). Request/grant handshake followed by a
// single-cycle rvalid pulse carrying the fetched word.
interface instruction_fetch_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-issue fetch stage. Owns the program counter, fetches one word at a
// time over the instruction memory bus and holds it, with its PC, until the
// decode stage accepts it. The accept cycle selects the next PC.
//
// Optional feature: define FETCH_MISALIGN_CHK_EN to trap on a next PC whose
// low two bits are non-zero (adds output fetch_misalign and a TRAP state).
// Without it the low two bits of the next PC are simply cleared.
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  imem,
  input  logic [1:0]           pc_select,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic                 inst_ready,
  output logic                 inst_valid,
  output logic [XLEN-1:0]      inst,
  output logic [XLEN-1:0]      inst_pc,
  output logic [XLEN-1:0]      pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                 fetch_misalign
`endif
);

  localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] CLEAR_BIT0 = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] CLEAR_LOW2 = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    RESET_WAIT,
    REQ,
    WAIT_RSP,
    HOLD
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    TRAP
`endif
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            accept;

  // Link value for the instruction being presented; wraps silently.
  assign pc_plus4  = inst_pc + 32'd4;
  assign accept    = inst_valid && inst_ready;
  // The fetch address is the registered fetch PC; in TRAP it shows the fault.
  assign imem.addr = fetch_pc;

  // Next-PC selection from the downstream control code, using inst_pc as the PC term.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    target = pc_plus4;
    case (pc_select)
      2'b01:   target = inst_pc + imm;
      2'b10:   target = (rs1_data + imm) & CLEAR_BIT0;
      default: target = pc_plus4;
    endcase
`ifdef FETCH_MISALIGN_CHK_EN
    next_pc = target;
`else
    next_pc = target & CLEAR_LOW2;
`endif
  end

  // Fetch FSM with registered request and instruction outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_WAIT;
      fetch_pc   <= RESET_PC;
      imem.req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP;
      inst_pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        RESET_WAIT: begin
          imem.req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          // rvalid here is a protocol error and is deliberately ignored.
          if (imem.gnt) begin
            imem.req <= 1'b0;
            state    <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (imem.rvalid) begin
            inst       <= imem.rdata;
            inst_pc    <= fetch_pc;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            fetch_pc   <= next_pc;
            inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (next_pc[1:0] != 2'b00) begin
              fetch_misalign <= 1'b1;
              state          <= TRAP;
            end else begin
              imem.req <= 1'b1;
              state    <= REQ;
            end
`else
            imem.req <= 1'b1;
            state    <= REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        TRAP: begin
          // Terminal until reset.
          state <= TRAP;
        end
`endif
        default: begin
          state <= RESET_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a small instruction memory
// model whose grant and response delays are adjustable. Works with and
// without FETCH_MISALIGN_CHK_EN.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_select;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch_if #(.XLEN(32)) imem ();

  instruction_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .pc_select  (pc_select),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .pc_plus4   (pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed word at 0x100, otherwise {addr[15:0], 16'h0013}.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], 16'h0013};
  endfunction

  // Memory model: grant after gnt_delay cycles of req, respond rsp_delay
  // cycles after the earliest legal response cycle. Not reset by rst_n.
  int          gnt_delay = 0;
  int          rsp_delay = 0;
  int          req_cnt   = 0;
  int          rsp_cnt   = 0;
  bit          pend      = 1'b0;
  logic [31:0] rsp_addr  = '0;

  assign imem.gnt = imem.req && (req_cnt >= gnt_delay);

  initial begin
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
  end

  always @(posedge clk) begin
    if (imem.req && !imem.gnt) req_cnt <= req_cnt + 1;
    else                       req_cnt <= 0;
    imem.rvalid <= 1'b0;
    if (imem.req && imem.gnt) begin
      rsp_addr <= imem.addr;
      if (rsp_delay == 0) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= word(imem.addr);
      end else begin
        pend    <= 1'b1;
        rsp_cnt <= rsp_delay - 1;
      end
    end else if (pend) begin
      if (rsp_cnt == 0) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= word(rsp_addr);
        pend        <= 1'b0;
      end else begin
        rsp_cnt <= rsp_cnt - 1;
      end
    end
  end

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!inst_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: inst_valid=%b after %0d cycles, required 1", inst_valid, cycles);
    end
  endtask

  // Wait for an instruction, accept it with the given next-PC inputs and
  // check the next fetch request one cycle later.
  task automatic accept(input logic [1:0] sel, input logic [31:0] i, input logic [31:0] r,
                        input logic [31:0] exp_addr, input string name);
    int cyc;
    wait_valid(cyc);
    pc_select  = sel;
    imm        = i;
    rs1_data   = r;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== exp_addr) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h, required req=1 addr=%h", name, imem.req, imem.addr, exp_addr);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (imem.req !== 1'b0 || imem.addr !== RESET_PC || inst_valid !== 1'b0 ||
        inst !== NOP || inst_pc !== RESET_PC) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h valid=%b inst=%h pc=%h, required 0 %h 0 %h %h",
               name, imem.req, imem.addr, inst_valid, inst, inst_pc, RESET_PC, NOP, RESET_PC);
    end
  endtask

  task automatic test_reset;
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
`ifdef FETCH_MISALIGN_CHK_EN
    checks++;
    if (fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_misalign: fetch_misalign=%b, required 0", fetch_misalign);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, required 1 00000100 0", imem.req, imem.addr, inst_valid);
    end
    @(negedge clk);
    checks++;
    if (imem.req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_wait: req=%b valid=%b, required 0 0", imem.req, inst_valid);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== 32'h100 || pc_plus4 !== 32'h104) begin
      errors++;
      $display("FAIL first_inst: valid=%b inst=%h pc=%h pc4=%h, required 1 00500093 00000100 00000104",
               inst_valid, inst, inst_pc, pc_plus4);
    end
  endtask

  task automatic test_sequential_and_branch;
    int cyc;
    accept(2'b00, 32'h0, 32'h0, 32'h104, "seq_addr");
    wait_valid(cyc);
    checks++;
    if (cyc != 2 || inst !== 32'h0104_0013 || inst_pc !== 32'h104) begin
      errors++;
      $display("FAIL seq_inst: cycles=%0d inst=%h pc=%h, required 2 01040013 00000104", cyc, inst, inst_pc);
    end
    accept(2'b01, 32'hFFFF_FFF8, 32'h0, 32'hFC, "branch_addr");
    wait_valid(cyc);
    checks++;
    if (inst !== 32'h00FC_0013 || inst_pc !== 32'hFC) begin
      errors++;
      $display("FAIL branch_inst: inst=%h pc=%h, required 00fc0013 000000fc", inst, inst_pc);
    end
  endtask

  task automatic test_jalr_and_wrap;
    int cyc;
    accept(2'b10, 32'h4, 32'h2001, 32'h2004, "jalr_addr");
    wait_valid(cyc);
    checks++;
    if (inst !== 32'h2004_0013 || inst_pc !== 32'h2004 || pc_plus4 !== 32'h2008) begin
      errors++;
      $display("FAIL jalr_inst: inst=%h pc=%h pc4=%h, required 20040013 00002004 00002008", inst, inst_pc, pc_plus4);
    end
    accept(2'b11, 32'h40, 32'h0, 32'h2008, "sel11_addr");
    accept(2'b10, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "high_addr");
    wait_valid(cyc);
    checks++;
    if (inst_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc4: pc=%h pc4=%h, required fffffffc 00000000", inst_pc, pc_plus4);
    end
    accept(2'b00, 32'h0, 32'h0, 32'h0, "wrap_addr");
  endtask

  task automatic test_back_pressure;
    int          cyc;
    int          n;
    logic [31:0] held_inst;
    logic [31:0] held_pc;
    wait_valid(cyc);
    held_inst = inst;
    held_pc   = inst_pc;
    inst_ready = 1'b0;
    gnt_delay  = 3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst !== held_inst || inst_pc !== held_pc || imem.req !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b inst=%h pc=%h req=%b, required 1 %h %h 0",
                 k, inst_valid, inst, inst_pc, imem.req, held_inst, held_pc);
      end
    end
    accept(2'b00, 32'h0, 32'h0, 32'h4, "bp_addr");
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!imem.req) break;
      n++;
      checks++;
      if (imem.addr !== 32'h4) begin
        errors++;
        $display("FAIL bp_addr_stable: addr=%h, required 00000004", imem.addr);
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_req_cycles: req high %0d cycles, required 4", n);
    end
    gnt_delay = 0;
    wait_valid(cyc);
    checks++;
    if (inst !== 32'h0004_0013 || inst_pc !== 32'h4 || imem.req !== 1'b0) begin
      errors++;
      $display("FAIL bp_inst: inst=%h pc=%h req=%b, required 00040013 00000004 0", inst, inst_pc, imem.req);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    rsp_delay = 2;
    accept(2'b00, 32'h0, 32'h0, 32'h8, "mid_addr");
    @(negedge clk);
    checks++;
    if (imem.req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait: req=%b valid=%b, required 0 0", imem.req, inst_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset_rvalid");
    rsp_delay = 0;
    @(negedge clk);
    check_reset_outputs("mid_reset_after");
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin
      errors++;
      $display("FAIL mid_refetch: req=%b addr=%h, required 1 %h", imem.req, imem.addr, RESET_PC);
    end
    wait_valid(cyc);
    checks++;
    if (inst !== 32'h0050_0093 || inst_pc !== RESET_PC) begin
      errors++;
      $display("FAIL mid_inst: inst=%h pc=%h, required 00500093 %h", inst, inst_pc, RESET_PC);
    end
  endtask

  task automatic test_misalign;
`ifdef FETCH_MISALIGN_CHK_EN
    int cyc;
    wait_valid(cyc);
    pc_select  = 2'b01;
    imm        = 32'h6;
    rs1_data   = 32'h0;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (fetch_misalign !== 1'b1 || imem.addr !== 32'h106 || imem.req !== 1'b0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL trap[%0d]: misalign=%b addr=%h req=%b valid=%b, required 1 00000106 0 0",
                 k, fetch_misalign, imem.addr, imem.req, inst_valid);
      end
      inst_ready = 1'b1;
      @(negedge clk);
    end
    inst_ready = 1'b0;
`else
    accept(2'b01, 32'h6, 32'h0, 32'h104, "misalign_cleared");
`endif
  endtask

  initial begin
    pc_select  = 2'b00;
    imm        = '0;
    rs1_data   = '0;
    inst_ready = 1'b0;
    rst_n      = 1'b0;
    test_reset();
    test_sequential_and_branch();
    test_jalr_and_wrap();
    test_back_pressure();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Single-issue fetch stage that owns the program counter and drives the instruction memory request/response interface.
- Presents one instruction at a time, with its PC, to the decode/control stage.
- On acceptance of each instruction, computes the next PC from the downstream pc_select code (sequential, PC+offset, or rs1+offset), then issues the next fetch.
- Sits directly upstream of control_unit: its inst output is control_unit's instruction input.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_select  input  2  next-PC source; valid in the accept cycle. 00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1, 11 = PC+4.
- imm  input  32  sign-extended immediate from decode; valid in the accept cycle.
- rs1_data  input  32  register rs1 value; valid in the accept cycle.
- inst_ready  input  1  downstream accepts inst this cycle.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; word aligned.
- imem_gnt  input  1  memory accepted the request.
- imem_rvalid  input  1  imem_rdata valid.
- imem_rdata  input  32  fetched instruction word.
- inst_valid  output  1  inst and inst_pc are valid.
- inst  output  32  instruction to decode.
- inst_pc  output  32  PC of inst.
- pc_plus4  output  32  inst_pc+4; used as the link value (write_from = PC).

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert), outputs:
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0.
  - inst=32'h0000_0013 (NOP), inst_pc=RESET_PC.
  - Internal fetch_pc=RESET_PC; state=RESET_WAIT.
- FSM states: RESET_WAIT, REQ, WAIT_RSP, HOLD.
- RESET_WAIT: exactly one cycle after rst_n deasserts, then go to REQ.
- REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - Request and address stay stable until imem_gnt.
  - On gnt, drop imem_req the following cycle and go to WAIT_RSP.
- WAIT_RSP:
  - imem_req=0.
  - On imem_rvalid, register inst<=imem_rdata and inst_pc<=fetch_pc, set inst_valid=1, go to HOLD.
  - imem_rvalid in REQ, or coincident with gnt, is a protocol error and is ignored.
  - Responses are accepted earliest the cycle after gnt. Wait time in REQ and WAIT_RSP is unbounded.
- HOLD:
  - inst, inst_pc, and inst_valid stay stable until inst_ready=1.
  - On inst_valid&&inst_ready (the accept cycle):
    - Compute next_pc from pc_select, imm, and rs1_data sampled that cycle, using inst_pc as the PC term.
    - fetch_pc<=next_pc, inst_valid<=0, go to REQ.
  - Minimum throughput: one instruction per 3 cycles with zero-wait memory. Latency is 2 cycles from gnt to inst_valid with rvalid one cycle after gnt.
- Arithmetic: all additions are modulo 2^32, with wrap-around silent (32'hFFFF_FFFC+4 = 0). pc_plus4 is combinational from inst_pc.
- Alignment: next_pc bits[1:0] are handled per the optional feature.
- Reset mid-transaction:
  - Outstanding gnt/rvalid is discarded. The FSM returns to RESET_WAIT and the first fetch is RESET_PC.
  - Memory must drop stale responses on reset; this block ignores rvalid outside WAIT_RSP.
- inst_ready outside HOLD has no effect.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0) and state TRAP.
  - In the accept cycle, if next_pc[1:0]!=0, go to TRAP instead of REQ. fetch_misalign=1, imem_req=0, inst_valid=0, and the faulting next_pc is held in imem_addr.
  - TRAP is left only by reset.
- Undefined: next_pc[1:0] is forced to 2'b00 and no trap exists.

Test Plan:
- Reset release with RESET_PC=32'h100 and zero-wait memory (gnt same cycle as req, rvalid next cycle), rdata=32'h0050_0093 -> imem_addr=32'h100, inst_valid rises 3 cycles after rst_n deassert, inst_pc=32'h100, pc_plus4=32'h104.
- Accept with pc_select=00, then pc_select=01 with imm=32'hFFFF_FFF8 -> fetch addresses 32'h104, then 32'hFC.
- pc_select=10 with rs1_data=32'h2001 and imm=32'h4 -> next fetch address 32'h2004.
- Backpressure: inst_ready held low for 5 cycles, memory gnt delayed 3 cycles -> inst and inst_pc stable throughout, no second imem_req, imem_addr stable while req is high.
- rst_n asserted in WAIT_RSP with rvalid arriving during reset -> outputs return to reset values, next fetch address is RESET_PC, stale rdata is never presented.
- With FETCH_MISALIGN_CHK_EN: pc_select=01, inst_pc=32'h100, imm=32'h6 -> fetch_misalign=1, imem_addr=32'h106, no request. Without the macro: fetch address is 32'h104.
